sequence_ram_ctrl: RTL and testbench

//  Sequences the memory-game Nx4 sync RAM (registered address, q valid 1 clk after addr).

---
 rtl/sequence_ram_ctrl_pkg.sv | 25 ++
 rtl/sequence_ram_ctrl_timer.sv | 27 ++
 rtl/sequence_ram_ctrl.sv | 196 +++++++++++++++++++
 tb/tb_sequence_ram_ctrl.sv | 325 ++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/sequence_ram_ctrl_pkg.sv
// Shared state encodings, default timing values and a sizing helper.
// These are used by the memory-game sequence RAM controller.
package sequence_ram_ctrl_pkg;

    typedef enum logic [2:0] {
        ST_IDLE    = 3'd0,
        ST_APPEND  = 3'd1,
        ST_S_FETCH = 3'd2,
        ST_S_ON    = 3'd3,
        ST_S_OFF   = 3'd4,
        ST_C_PREP  = 3'd5,
        ST_C_WAIT  = 3'd6
    } state_e;

    localparam int unsigned DEF_SHOW_CYCLES = 1000;
    localparam int unsigned DEF_GAP_CYCLES  = 500;

    // Width of a down-counter that must hold the larger of the two phase lengths.
    function automatic int unsigned timer_width(input int unsigned a, input int unsigned b);
        int unsigned m;
        m = (a > b) ? a : b;
        return $clog2(m + 1);
    endfunction

endpackage

// File: rtl/sequence_ram_ctrl_timer.sv
// Phase timer for replay: loaded with (cycles-1) on phase entry.
// It then counts down to zero, where done is raised.
module seq_timer #(
    parameter int unsigned W = 4
) (
    input  logic         clk_i,
    input  logic         rst_ni,
    input  logic         load_i,
    input  logic [W-1:0] load_val_i,
    output logic         done_o
);

    logic [W-1:0] count_q;

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            count_q <= '0;
        end else if (load_i) begin
            count_q <= load_val_i;
        end else if (count_q != '0) begin
            count_q <= count_q - 1'b1;
        end
    end

    assign done_o = (count_q == '0);

endmodule

// File: rtl/sequence_ram_ctrl.sv
// Owns the memory-game sequence RAM port: appends plays, replays the stored
// sequence on the leds with on/off timing, and checks player inputs entry by entry.
module sequence_ram_ctrl
    import sequence_ram_ctrl_pkg::*;
#(
    parameter int unsigned N           = 256,
    parameter int unsigned SHOW_CYCLES = DEF_SHOW_CYCLES,
    parameter int unsigned GAP_CYCLES  = DEF_GAP_CYCLES,
    localparam int unsigned AW         = $clog2(N)
) (
    input  logic          clk_i,
    input  logic          reset_n_i,
    input  logic          cmd_clear_i,
    input  logic          cmd_append_i,
    input  logic [3:0]    append_value_i,
    input  logic          cmd_show_i,
    input  logic          cmd_check_i,
    input  logic          play_valid_i,
    input  logic [3:0]    play_value_i,
    output logic          ram_we_o,
    output logic [AW-1:0] ram_addr_o,
    output logic [3:0]    ram_data_o,
    input  logic [3:0]    ram_q_i,
    output logic [3:0]    leds_o,
    output logic          busy_o,
    output logic [AW:0]   len_o,
    output logic          full_o,
    output logic          show_done_o,
    output logic          hit_o,
    output logic          round_ok_o,
    output logic          miss_o
);

    localparam int unsigned TW      = timer_width(SHOW_CYCLES, GAP_CYCLES);
    localparam logic [AW:0] LEN_MAX = (AW+1)'(N);

    state_e        state_q, state_d;
    logic [AW-1:0] idx_q, idx_d;
    logic [AW:0]   len_q, len_d;
    logic [3:0]    data_q, data_d;
    logic          show_done_q, show_done_d;
    logic          hit_q, hit_d;
    logic          round_ok_q, round_ok_d;
    logic          miss_q, miss_d;

    logic          full;
    logic          is_last;
    logic          match;
    logic          timer_load;
    logic [TW-1:0] timer_val;
    logic          timer_done;

    assign full    = (len_q == LEN_MAX);
    assign is_last = ({1'b0, idx_q} == (len_q - 1'b1));
    assign match   = (play_value_i == ram_q_i);

    seq_timer #(.W(TW)) u_timer (
        .clk_i      (clk_i),
        .rst_ni     (reset_n_i),
        .load_i     (timer_load),
        .load_val_i (timer_val),
        .done_o     (timer_done)
    );

    always_ff @(posedge clk_i or negedge reset_n_i) begin
        if (!reset_n_i) begin
            state_q     <= ST_IDLE;
            idx_q       <= '0;
            len_q       <= '0;
            data_q      <= '0;
            show_done_q <= 1'b0;
            hit_q       <= 1'b0;
            round_ok_q  <= 1'b0;
            miss_q      <= 1'b0;
        end else begin
            state_q     <= state_d;
            idx_q       <= idx_d;
            len_q       <= len_d;
            data_q      <= data_d;
            show_done_q <= show_done_d;
            hit_q       <= hit_d;
            round_ok_q  <= round_ok_d;
            miss_q      <= miss_d;
        end
    end

    always_comb begin
        state_d = state_q;
        idx_d   = idx_q;
        len_d   = len_q;
        data_d  = data_q;
        if (cmd_clear_i) begin
            state_d = ST_IDLE;
            idx_d   = '0;
            len_d   = '0;
        end else begin
            unique case (state_q)
                ST_IDLE: begin
                    if (cmd_append_i) begin
                        if (!full) begin
                            data_d  = append_value_i;
                            state_d = ST_APPEND;
                        end
                    end else if (cmd_show_i) begin
                        if (len_q != '0) begin
                            idx_d   = '0;
                            state_d = ST_S_FETCH;
                        end
                    end else if (cmd_check_i) begin
                        if (len_q != '0) begin
                            idx_d   = '0;
                            state_d = ST_C_PREP;
                        end
                    end
                end
                ST_APPEND: begin
                    len_d   = len_q + 1'b1;
                    state_d = ST_IDLE;
                end
                ST_S_FETCH: state_d = ST_S_ON;
                ST_S_ON: begin
                    if (timer_done) state_d = ST_S_OFF;
                end
                ST_S_OFF: begin
                    if (timer_done) begin
                        if (is_last) begin
                            state_d = ST_IDLE;
                        end else begin
                            idx_d   = idx_q + 1'b1;
                            state_d = ST_S_FETCH;
                        end
                    end
                end
                ST_C_PREP: state_d = ST_C_WAIT;
                ST_C_WAIT: begin
                    if (play_valid_i) begin
                        if (match && !is_last) begin
                            idx_d   = idx_q + 1'b1;
                            state_d = ST_C_PREP;
                        end else begin
                            state_d = ST_IDLE;
                        end
                    end
                end
                default: state_d = ST_IDLE;
            endcase
        end
    end

    always_comb begin
        timer_load  = (state_d != state_q) && ((state_d == ST_S_ON) || (state_d == ST_S_OFF));
        timer_val   = (state_d == ST_S_ON) ? TW'(SHOW_CYCLES - 1) : TW'(GAP_CYCLES - 1);

        show_done_d = 1'b0;
        hit_d       = 1'b0;
        round_ok_d  = 1'b0;
        miss_d      = 1'b0;
        if (!cmd_clear_i) begin
            show_done_d = ((state_q == ST_IDLE) && !cmd_append_i && cmd_show_i && (len_q == '0))
                       || ((state_q == ST_S_OFF) && timer_done && is_last);
            round_ok_d  = ((state_q == ST_IDLE) && !cmd_append_i && !cmd_show_i && cmd_check_i
                           && (len_q == '0))
                       || ((state_q == ST_C_WAIT) && play_valid_i && match && is_last);
            hit_d       = (state_q == ST_C_WAIT) && play_valid_i && match && !is_last;
            miss_d      = (state_q == ST_C_WAIT) && play_valid_i && !match;
        end

        ram_we_o   = 1'b0;
        ram_addr_o = '0;
        ram_data_o = '0;
        leds_o     = '0;
        unique case (state_q)
            ST_APPEND: begin
                ram_we_o   = 1'b1;
                ram_addr_o = len_q[AW-1:0];
                ram_data_o = data_q;
            end
            // Address stays on idx through the lit phase, so q is stable for its whole length.
            ST_S_ON: begin
                ram_addr_o = idx_q;
                leds_o     = ram_q_i;
            end
            ST_S_FETCH, ST_S_OFF, ST_C_PREP, ST_C_WAIT: ram_addr_o = idx_q;
            default: ram_addr_o = '0;
        endcase
    end

    assign busy_o      = (state_q != ST_IDLE);
    assign len_o       = len_q;
    assign full_o      = full;
    assign show_done_o = show_done_q;
    assign hit_o       = hit_q;
    assign round_ok_o  = round_ok_q;
    assign miss_o      = miss_q;

endmodule

// File: tb/tb_sequence_ram_ctrl.sv
// Bench for sequence_ram_ctrl with a behavioural 16x4 sync RAM (registered address);
// expected pulses and lit entries are queued by the tests and consumed by monitors.
module tb_sequence_ram_ctrl;

    localparam int N    = 16;
    localparam int SHOW = 4;
    localparam int GAP  = 2;
    localparam int AW   = 4;

    localparam logic [3:0] P_DONE = 4'b1000;
    localparam logic [3:0] P_HIT  = 4'b0100;
    localparam logic [3:0] P_OK   = 4'b0010;
    localparam logic [3:0] P_MISS = 4'b0001;

    logic          clk = 1'b0;
    logic          reset_n;
    logic          cmd_clear, cmd_append, cmd_show, cmd_check, play_valid;
    logic [3:0]    append_value, play_value;
    logic          ram_we;
    logic [AW-1:0] ram_addr;
    logic [3:0]    ram_data, ram_q, leds;
    logic          busy, full, show_done, hit, round_ok, miss;
    logic [AW:0]   len;

    int checks = 0;
    int errors = 0;
    int model_len = 0;
    logic [3:0] pulse_q[$];
    logic [3:0] led_q[$];

    always #5 clk = ~clk;

    sequence_ram_ctrl #(.N(N), .SHOW_CYCLES(SHOW), .GAP_CYCLES(GAP)) dut (
        .clk_i(clk), .reset_n_i(reset_n),
        .cmd_clear_i(cmd_clear), .cmd_append_i(cmd_append), .append_value_i(append_value),
        .cmd_show_i(cmd_show), .cmd_check_i(cmd_check),
        .play_valid_i(play_valid), .play_value_i(play_value),
        .ram_we_o(ram_we), .ram_addr_o(ram_addr), .ram_data_o(ram_data), .ram_q_i(ram_q),
        .leds_o(leds), .busy_o(busy), .len_o(len), .full_o(full),
        .show_done_o(show_done), .hit_o(hit), .round_ok_o(round_ok), .miss_o(miss)
    );

    // Sync RAM: q reflects the address presented one clock earlier.
    logic [3:0]    mem [N];
    logic [AW-1:0] ram_addr_q;
    always @(posedge clk) begin
        if (ram_we) mem[ram_addr] <= ram_data;
        ram_addr_q <= ram_addr;
    end
    assign ram_q = mem[ram_addr_q];

    always @(negedge clk) begin
        logic [3:0] pv, exp_p;
        pv = {show_done, hit, round_ok, miss};
        if (reset_n && pv != 4'b0) begin
            checks++;
            if (pulse_q.size() == 0) begin
                errors++;
                $display("FAIL pulse_unexpected: got %b, none expected", pv);
            end else begin
                exp_p = pulse_q.pop_front();
                if (pv !== exp_p) begin
                    errors++;
                    $display("FAIL pulse_order: got %b, expected %b", pv, exp_p);
                end
            end
        end
    end

    // Dark time between entries is the off phase plus the fetch cycle.
    logic [3:0] run_val;
    int run_len = 0, dark_len = 0;
    bit gap_armed = 0;
    always @(negedge clk) begin
        logic [3:0] exp_l;
        if (!reset_n) begin
            run_len = 0; dark_len = 0; gap_armed = 0;
        end else if (leds != 4'b0) begin
            if (run_len == 0) begin
                if (gap_armed) begin
                    checks++;
                    if (dark_len != GAP + 1) begin
                        errors++;
                        $display("FAIL led_gap: got %0d dark clks, expected %0d", dark_len, GAP + 1);
                    end
                end
                run_val = leds;
            end else if (leds !== run_val) begin
                checks++; errors++;
                $display("FAIL led_glitch: got %h during %h", leds, run_val);
            end
            run_len++;
        end else begin
            if (run_len > 0) begin
                checks++;
                if (led_q.size() == 0) begin
                    errors++;
                    $display("FAIL led_unexpected: got %h lit, none expected", run_val);
                end else begin
                    exp_l = led_q.pop_front();
                    if (run_val !== exp_l || run_len != SHOW) begin
                        errors++;
                        $display("FAIL led_entry: got %h for %0d clks, expected %h for %0d clks",
                                 run_val, run_len, exp_l, SHOW);
                    end
                end
                run_len = 0; dark_len = 1; gap_armed = 1;
            end else begin
                dark_len++;
            end
            if (busy !== 1'b1) gap_armed = 0;
        end
    end

    task automatic tick(input int n = 1);
        repeat (n) begin @(posedge clk); #1; end
    endtask

    task automatic do_clear();
        cmd_clear = 1; tick(); cmd_clear = 0;
        model_len = 0;
    endtask

    task automatic do_append(input logic [3:0] v);
        bit          will_write;
        logic [AW-1:0] exp_addr;
        will_write = (model_len < N);
        exp_addr   = AW'(model_len);
        cmd_append = 1; append_value = v; tick(); cmd_append = 0; append_value = 4'h0;
        checks++;
        if (ram_we !== will_write) begin
            errors++;
            $display("FAIL append_we: got %b, expected %b", ram_we, will_write);
        end
        if (will_write) begin
            checks++;
            if (ram_addr !== exp_addr || ram_data !== v) begin
                errors++;
                $display("FAIL append_port: got addr %0d data %h, expected addr %0d data %h",
                         ram_addr, ram_data, exp_addr, v);
            end
            model_len++;
        end
        tick();
        checks++;
        if (len !== (AW+1)'(model_len) || busy !== 1'b0) begin
            errors++;
            $display("FAIL append_len: got len %0d busy %b, expected len %0d busy 0", len, busy, model_len);
        end
    endtask

    task automatic wait_idle(input int budget, input string what);
        int n = 0;
        while (busy !== 1'b0 && n < budget) begin tick(); n++; end
        checks++;
        if (busy !== 1'b0) begin
            errors++;
            $display("FAIL %s_timeout: busy %b after %0d clks, expected 0", what, busy, budget);
        end
    endtask

    task automatic drain(input string what);
        tick(2);
        checks++;
        if (pulse_q.size() != 0 || led_q.size() != 0) begin
            errors++;
            $display("FAIL %s_drain: %0d pulses and %0d leds outstanding, expected 0",
                     what, pulse_q.size(), led_q.size());
        end
        pulse_q.delete(); led_q.delete();
    endtask

    task automatic play(input logic [3:0] v);
        play_valid = 1; play_value = v; tick(); play_valid = 0; play_value = 4'h0;
        tick(2);
    endtask

    task automatic test_reset();
        reset_n = 0; tick(3); reset_n = 1; tick();
        checks++;
        if (busy !== 0 || len !== 0 || leds !== 0 || full !== 0 || ram_we !== 0 || ram_addr !== 0
            || {show_done, hit, round_ok, miss} !== 4'b0) begin
            errors++;
            $display("FAIL reset_state: busy %b len %0d leds %h full %b we %b addr %0d pulses %b",
                     busy, len, leds, full, ram_we, ram_addr, {show_done, hit, round_ok, miss});
        end
        do_append(4'h9); do_append(4'h1);
        cmd_show = 1; tick(); cmd_show = 0;
        for (int i = 0; i < 20 && leds == 4'h0; i++) tick();
        tick();
        reset_n = 0; #1;
        checks++;
        if (leds !== 0 || busy !== 0 || len !== 0) begin
            errors++;
            $display("FAIL reset_mid_show: leds %h busy %b len %0d, expected 0 0 0", leds, busy, len);
        end
        model_len = 0;
        tick(2); reset_n = 1; tick(12);
        drain("reset");
    endtask

    task automatic test_append_show();
        do_clear();
        do_append(4'h3); do_append(4'h5); do_append(4'hA);
        led_q.push_back(4'h3); led_q.push_back(4'h5); led_q.push_back(4'hA);
        pulse_q.push_back(P_DONE);
        cmd_show = 1; tick(); cmd_show = 0;
        wait_idle(60, "show");
        checks++;
        if (len !== 3) begin
            errors++;
            $display("FAIL show_len: got %0d, expected 3", len);
        end
        drain("show");
    endtask

    task automatic test_check();
        pulse_q.push_back(P_HIT); pulse_q.push_back(P_HIT); pulse_q.push_back(P_OK);
        cmd_check = 1; tick(); cmd_check = 0; tick(2);
        play(4'h3); play(4'h5); play(4'hA);
        wait_idle(10, "check_ok");
        drain("check_ok");
        pulse_q.push_back(P_HIT); pulse_q.push_back(P_MISS);
        cmd_check = 1; tick(); cmd_check = 0; tick(2);
        play(4'h3); play(4'h7);
        checks++;
        if (busy !== 0 || len !== 3) begin
            errors++;
            $display("FAIL check_miss_idle: busy %b len %0d, expected 0 3", busy, len);
        end
        drain("check_miss");
    endtask

    task automatic test_full();
        do_clear();
        for (int i = 0; i < N; i++) do_append(4'(i));
        checks++;
        if (full !== 1 || len !== N) begin
            errors++;
            $display("FAIL full_flag: full %b len %0d, expected 1 %0d", full, len, N);
        end
        do_append(4'hF);
        checks++;
        if (full !== 1 || len !== N) begin
            errors++;
            $display("FAIL full_hold: full %b len %0d, expected 1 %0d", full, len, N);
        end
        do_clear();
        pulse_q.push_back(P_DONE);
        cmd_show = 1; tick(); cmd_show = 0;
        checks++;
        if (show_done !== 1 || busy !== 0 || full !== 0) begin
            errors++;
            $display("FAIL empty_show: done %b busy %b full %b, expected 1 0 0", show_done, busy, full);
        end
        tick(10);
        drain("empty_show");
    endtask

    task automatic test_clear_in_wait();
        do_clear();
        do_append(4'h4); do_append(4'h8);
        cmd_check = 1; tick(); cmd_check = 0; tick(2);
        cmd_clear = 1; play_valid = 1; play_value = 4'h7; tick();
        cmd_clear = 0; play_valid = 0; play_value = 4'h0;
        model_len = 0;
        checks++;
        if (busy !== 0 || len !== 0 || ram_we !== 0 || leds !== 0) begin
            errors++;
            $display("FAIL clear_wait: busy %b len %0d we %b leds %h, expected 0 0 0 0",
                     busy, len, ram_we, leds);
        end
        drain("clear_wait");
    endtask

    task automatic test_back_to_back();
        do_clear();
        cmd_append = 1; cmd_show = 1; append_value = 4'h6; tick();
        cmd_append = 0; cmd_show = 0; append_value = 4'h0;
        checks++;
        if (ram_we !== 1 || ram_data !== 4'h6 || ram_addr !== 0) begin
            errors++;
            $display("FAIL b2b_append: we %b data %h addr %0d, expected 1 6 0", ram_we, ram_data, ram_addr);
        end
        tick(3);
        checks++;
        if (busy !== 0 || len !== 1) begin
            errors++;
            $display("FAIL b2b_no_show: busy %b len %0d, expected 0 1", busy, len);
        end
        led_q.push_back(4'h6);
        pulse_q.push_back(P_DONE);
        cmd_show = 1; tick(); cmd_show = 0; tick(2);
        cmd_show = 1; cmd_append = 1; append_value = 4'h9; tick();
        cmd_show = 0; cmd_append = 0; append_value = 4'h0;
        wait_idle(30, "b2b");
        tick(8);
        checks++;
        if (len !== 1 || busy !== 0) begin
            errors++;
            $display("FAIL b2b_busy_drop: len %0d busy %b, expected 1 0", len, busy);
        end
        drain("b2b");
    endtask

    initial begin
        reset_n = 0; cmd_clear = 0; cmd_append = 0; cmd_show = 0; cmd_check = 0;
        play_valid = 0; append_value = 0; play_value = 0;
        test_reset();
        test_append_show();
        test_check();
        test_full();
        test_clear_in_wait();
        test_back_to_back();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, checks %0d", checks);
        $fatal(1, "watchdog");
    end

endmodule
